tt_sweep_checker: RTL and testbench

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

---
 rtl/tt_sweep_checker.sv | 137 +++++++++++++
 tb/tb_tt_sweep_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// Sweeps a 3-input logic block through rows 0..7, captures its truth table and compares it to EXPECTED.
// Optional TT_SWEEP_SYNC_EN adds a 2-flop synchronizer on out_dut and extends each row by two cycles.
module tt_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED      = 8'h1E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       out_dut,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt_observed,
    output logic [3:0] mismatch_cnt
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("tt_sweep_checker: SETTLE_CYCLES must be in 1..255");
    end

`ifdef TT_SWEEP_SYNC_EN
    localparam int unsigned HOLD = SETTLE_CYCLES + 2;
`else
    localparam int unsigned HOLD = SETTLE_CYCLES;
`endif
    // APPLY covers the first HOLD-1 cycles of a row; SAMPLE is the last hold cycle.
    localparam logic [7:0] LAST_APPLY = (HOLD >= 2) ? 8'(HOLD - 2) : 8'd0;

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  row_q, row_d;
    logic [7:0]  tt_q, tt_d;
    logic [3:0]  mm_q, mm_d;
    logic        pass_q, pass_d;
    logic        sample_bit;

`ifdef TT_SWEEP_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= out_dut;
            sync2_q <= sync1_q;
        end
    end

    assign sample_bit = sync2_q;
`else
    assign sample_bit = out_dut;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        tt_d    = tt_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (HOLD == 1) ? SAMPLE : APPLY;
                    cnt_d   = '0;
                    row_d   = '0;
                    tt_d    = '0;
                    mm_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                if (cnt_q == LAST_APPLY) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                tt_d[3'd7 - row_q] = sample_bit;
                if (sample_bit != EXPECTED[3'd7 - row_q]) begin
                    mm_d = mm_q + 4'd1;
                end
                if (row_q == 3'd7) begin
                    state_d = FINISH;
                    row_d   = '0;
                    pass_d  = (tt_d == EXPECTED);
                end else begin
                    state_d = (HOLD == 1) ? SAMPLE : APPLY;
                    row_d   = row_q + 3'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            tt_q    <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
        end
    end

    assign in1          = row_q[2];
    assign in2          = row_q[1];
    assign in3          = row_q[0];
    assign busy         = (state_q == APPLY) || (state_q == SAMPLE);
    assign done         = (state_q == FINISH);
    assign pass         = pass_q;
    assign tt_observed  = tt_q;
    assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: timeline-based reference model checked every cycle, plus literal checks.
// Honours TT_SWEEP_SYNC_EN for row hold length and done latency.
module tb_tt_sweep_checker;

    localparam logic [7:0] EXP = 8'h1E;
`ifdef TT_SWEEP_SYNC_EN
    localparam int H       = 6;
    localparam int LAT     = 49;
    localparam int N_DONE80 = 1;
`else
    localparam int H       = 4;
    localparam int LAT     = 33;
    localparam int N_DONE80 = 2;
`endif

    logic       clk = 1'b0;
    logic       rst, start;
    logic       in1, in2, in3, out_dut;
    logic       busy, done, pass;
    logic [7:0] tt_observed;
    logic [3:0] mismatch_cnt;

    int         mode;
    logic [7:0] rtab;
    int         tests = 0;
    int         fails = 0;
    logic       chk_en = 1'b0;

    // model state: k = cycle index within current sweep (0 = idle)
    int         k = 0;
    logic [7:0] m_tt = '0;
    int         m_mm = 0;
    logic       m_pass = 1'b0;

    always #5 clk = ~clk;

    tt_sweep_checker #(.SETTLE_CYCLES(4), .EXPECTED(8'h1E)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in1(in1), .in2(in2), .in3(in3), .out_dut(out_dut),
        .busy(busy), .done(done), .pass(pass),
        .tt_observed(tt_observed), .mismatch_cnt(mismatch_cnt)
    );

    function automatic logic block_fn(int md, logic [2:0] r);
        logic [7:0] t;
        t = rtab;
        case (md)
            0:       return r[2] ^ (r[1] & r[0]);
            1:       return 1'b0;
            2:       return ~(r[2] ^ (r[1] & r[0]));
            default: return t[7 - r];
        endcase
    endfunction

    assign out_dut = block_fn(mode, {in1, in2, in3});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            k = 0; m_tt = '0; m_mm = 0; m_pass = 1'b0;
        end else if (k == 0) begin
            if (start) begin
                k = 1; m_tt = '0; m_mm = 0; m_pass = 1'b0;
            end
        end else begin
            if (k <= 8 * H && k % H == 0) begin
                int r;
                logic b;
                r = k / H - 1;
                b = block_fn(mode, 3'(r));
                m_tt[7 - r] = b;
                if (b != EXP[7 - r]) m_mm++;
                if (r == 7) m_pass = (m_tt == EXP);
            end
            k = (k == 8 * H + 1) ? 0 : k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic       e_busy;
            logic [2:0] e_row;
            e_busy = (k >= 1 && k <= 8 * H);
            e_row  = e_busy ? 3'((k - 1) / H) : 3'd0;
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(k == 8 * H + 1));
            check("row", 32'({in1, in2, in3}), 32'(e_row));
            check("tt_observed", 32'(tt_observed), 32'(m_tt));
            check("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mm));
            check("pass", 32'(pass), 32'(m_pass));
        end
    end

    task automatic sweep_latency(output int n);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (done) break;
            if (n > 400) begin
                check("done_timeout", 32'(n), 32'(LAT));
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (k != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (k != 0) check("idle_timeout", 32'(k), 32'd0);
    endtask

    initial begin
        int n, dn;
        rst = 1'b1; start = 1'b0; mode = 0; rtab = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_tt", 32'(tt_observed), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pins", 32'({in1, in2, in3}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        mode = 0;
        sweep_latency(n);
        check("lat_correct", 32'(n), 32'(LAT));
        check("tt_correct", 32'(tt_observed), 32'h1E);
        check("mm_correct", 32'(mismatch_cnt), 32'd0);
        check("pass_correct", 32'(pass), 32'd1);
        repeat (3) @(negedge clk);
        check("hold_tt", 32'(tt_observed), 32'h1E);
        check("hold_pass", 32'(pass), 32'd1);

        mode = 1;
        sweep_latency(n);
        check("tt_stuck0", 32'(tt_observed), 32'h00);
        check("mm_stuck0", 32'(mismatch_cnt), 32'd4);
        check("pass_stuck0", 32'(pass), 32'd0);

        mode = 2;
        sweep_latency(n);
        check("tt_inv", 32'(tt_observed), 32'hE1);
        check("mm_inv", 32'(mismatch_cnt), 32'd8);
        check("pass_inv", 32'(pass), 32'd0);

        // reset mid-sweep during row 3, with start held alongside rst
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while ({in1, in2, in3} != 3'd3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_row3", 32'({in1, in2, in3}), 32'd3);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tt", 32'(tt_observed), 32'h00);
        check("midrst_mm", 32'(mismatch_cnt), 32'd0);
        check("midrst_pins", 32'({in1, in2, in3}), 32'd0);
        @(negedge clk);
        check("rst_start_ignored", 32'(busy), 32'd0);
        sweep_latency(n);
        check("lat_after_rst", 32'(n), 32'(LAT));
        check("tt_after_rst", 32'(tt_observed), 32'h1E);
        @(negedge clk);

        // start held high for 80 cycles
        dn = 0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        start = 1'b0;
        check("done_count_80", 32'(dn), 32'(N_DONE80));
        wait_idle();

        // randomized tables, stray starts and occasional mid-sweep resets
        for (int it = 0; it < 30; it++) begin
            int abort_at;
            wait_idle();
            mode = 3;
            rtab = 8'($urandom);
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 8 * H)) : -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int c = 0; c < 8 * H + 6; c++) begin
                start = (c == 0) || ($urandom_range(0, 3) == 0);
                rst   = (c == abort_at);
                @(negedge clk);
            end
            start = 1'b0; rst = 1'b0;
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
